// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: memory-op codes, FSM states, and
// op-classification helpers used by both the stage and its load extender.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LH   = 4'd2,
        MEMOP_LW   = 4'd3,
        MEMOP_LBU  = 4'd4,
        MEMOP_LHU  = 4'd5,
        MEMOP_SB   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic        RST_ENABLE = 1'b1;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW) ||
               (op == MEMOP_LBU) || (op == MEMOP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    // Bytes moved by an op; zero for anything that is not a memory access.
    function automatic logic [2:0] xfer_len(input logic [3:0] op);
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: return 3'd1;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: return 3'd2;
            MEMOP_LW, MEMOP_SW:            return 3'd4;
            default:                       return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Combinational sign/zero extension of the assembled little-endian load bytes.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [3:0]  memop,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    always_comb begin
        result = ZERO_WORD;
        case (memop)
            MEMOP_LB:  result = {{24{raw[7]}}, raw[7:0]};
            MEMOP_LBU: result = {24'd0, raw[7:0]};
            MEMOP_LH:  result = {{16{raw[15]}}, raw[15:0]};
            MEMOP_LHU: result = {16'd0, raw[15:0]};
            MEMOP_LW:  result = raw;
            default:   result = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: serialises loads/stores onto a byte-wide synchronous
// RAM, stalling upstream until the access completes.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        memop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    input  logic [7:0]        ram_din_i,
    output logic [RAM_AW-1:0] ram_a_o,
    output logic [7:0]        ram_d_o,
    output logic              ram_wr_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stall_req_o
);

    state_e      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [31:0] data_reg, data_next;

    logic        load_op;
    logic        store_op;
    logic [2:0]  len;
    logic [2:0]  cnt_prev;
    logic [31:0] byte_addr;
    logic [31:0] load_val;

    assign load_op   = is_load(memop_i);
    assign store_op  = is_store(memop_i);
    assign len       = xfer_len(memop_i);
    assign cnt_prev  = cnt_reg - 3'd1;
    assign byte_addr = mem_addr_i + {29'd0, cnt_reg};

    mem_load_ext u_load_ext (
        .memop  (memop_i),
        .raw    (data_reg),
        .result (load_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
            data_reg  <= ZERO_WORD;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
        end
    end

    // Outputs are gated by rst directly so a mid-transfer reset kills the
    // write strobe in the same cycle rather than at the next edge.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        data_next   = data_reg;
        ram_a_o     = '0;
        ram_d_o     = 8'h00;
        ram_wr_o    = 1'b0;
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = ZERO_WORD;
        stall_req_o = 1'b0;

        if (rst != RST_ENABLE) begin
            wd_o    = wd_i;
            wdata_o = wdata_i;
            case (state_reg)
                ST_IDLE: begin
                    if (load_op || store_op) begin
                        stall_req_o = 1'b1;
                        cnt_next    = 3'd0;
                        data_next   = ZERO_WORD;
                        state_next  = ST_XFER;
                    end else begin
                        wreg_o = wreg_i;
                    end
                end
                ST_XFER: begin
                    stall_req_o = 1'b1;
                    if (store_op) begin
                        ram_a_o  = byte_addr[RAM_AW-1:0];
                        ram_d_o  = mem_data_i[{cnt_reg[1:0], 3'b000} +: 8];
                        ram_wr_o = 1'b1;
                        cnt_next = cnt_reg + 3'd1;
                        if (cnt_reg == len - 3'd1)
                            state_next = ST_FINISH;
                    end else if (load_op) begin
                        // RAM read data lags its address by one cycle, so
                        // byte k arrives while cnt is k+1.
                        if (cnt_reg < len)
                            ram_a_o = byte_addr[RAM_AW-1:0];
                        if (cnt_reg != 3'd0)
                            data_next[{cnt_prev[1:0], 3'b000} +: 8] = ram_din_i;
                        cnt_next = cnt_reg + 3'd1;
                        if (cnt_reg == len)
                            state_next = ST_FINISH;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_FINISH: begin
                    wreg_o     = wreg_i;
                    wdata_o    = load_op ? load_val : wdata_i;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
            if (wd_o == 5'd0)
                wreg_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, reset-abort sequence and
// randomized ops checked against a byte-array memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int RAM_AW   = 17;
    localparam int RAM_SIZE = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4:0]        wd_i = '0;
    logic              wreg_i = 1'b0;
    logic [31:0]       wdata_i = '0;
    logic [3:0]        memop_i = '0;
    logic [31:0]       mem_addr_i = '0;
    logic [31:0]       mem_data_i = '0;
    logic [7:0]        ram_din_i;
    logic [RAM_AW-1:0] ram_a_o;
    logic [7:0]        ram_d_o;
    logic              ram_wr_o;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [31:0]       wdata_o;
    logic              stall_req_o;

    mem_stage #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .memop_i(memop_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .ram_din_i(ram_din_i), .ram_a_o(ram_a_o), .ram_d_o(ram_d_o),
        .ram_wr_o(ram_wr_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    // Byte-wide synchronous RAM attached to the DUT.
    logic [7:0] ram [0:RAM_SIZE-1];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        ram_q <= ram[ram_a_o];
        if (ram_wr_o) ram[ram_a_o] <= ram_d_o;
    end
    assign ram_din_i = ram_q;

    // Reference memory: what the RAM must hold according to the store rules.
    logic [7:0] ref_mem [int];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: return 1;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: return 2;
            MEMOP_LW, MEMOP_SW:            return 4;
            default:                       return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return op == MEMOP_SB || op == MEMOP_SH || op == MEMOP_SW;
    endfunction

    function automatic int mask_addr(input longint a);
        return int'(a & longint'(RAM_SIZE - 1));
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr);
        longint v = 0;
        int n = op_bytes(op);
        for (int k = 0; k < n; k++)
            v += longint'(ref_mem[mask_addr(longint'(addr) + k)]) << (8 * k);
        if ((op == MEMOP_LB || op == MEMOP_LH) && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic int model_stall(input logic [3:0] op);
        int n = op_bytes(op);
        if (n == 0) return 0;
        return op_is_store(op) ? n + 1 : n + 2;
    endfunction

    // One pipeline transaction: drive after a rising edge, observe on falling edges.
    task automatic run_op(input string name, input logic [3:0] op, input logic [4:0] wd,
                          input logic wreg, input logic [31:0] wdata, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_wdata,
                          input logic exp_wreg, input int exp_stall);
        int          stall_cycles = 0;
        logic        bad_wreg = 1'b0;
        int          wcyc[$];
        logic [31:0] wadr[$];
        logic [7:0]  wdat[$];
        int          n;
        @(posedge clk);
        #1;
        memop_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
        mem_addr_i = addr; mem_data_i = data;
        @(negedge clk);
        while (stall_req_o === 1'b1 && stall_cycles < 20) begin
            if (wreg_o !== 1'b0) bad_wreg = 1'b1;
            if (ram_wr_o === 1'b1) begin
                wcyc.push_back(stall_cycles);
                wadr.push_back(32'(ram_a_o));
                wdat.push_back(ram_d_o);
            end
            stall_cycles++;
            @(negedge clk);
        end
        check({name, " stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
        check({name, " wreg_during_stall"}, {31'd0, bad_wreg}, 32'd0);
        check({name, " wdata_o"}, wdata_o, exp_wdata);
        check({name, " wreg_o"}, {31'd0, wreg_o}, {31'd0, exp_wreg});
        check({name, " wd_o"}, {27'd0, wd_o}, {27'd0, wd});
        check({name, " ram_wr_idle"}, {31'd0, ram_wr_o}, 32'd0);
        if (op_is_store(op)) begin
            n = op_bytes(op);
            check({name, " write_count"}, 32'(wcyc.size()), 32'(n));
            for (int k = 0; k < n && k < wcyc.size(); k++) begin
                check({name, " write_cycle"}, 32'(wcyc[k]), 32'(k + 1));
                check({name, " write_addr"}, wadr[k], 32'(mask_addr(longint'(addr) + k)));
                check({name, " write_byte"}, {24'd0, wdat[k]}, {24'd0, data[8*k +: 8]});
            end
            for (int k = 0; k < n; k++)
                ref_mem[mask_addr(longint'(addr) + k)] = data[8*k +: 8];
        end
        $display("txn %s op=%0d addr=0x%08h wd=%0d wdata_o=0x%08h wreg_o=%0d stall=%0d",
                 name, op, addr, wd_o, wdata_o, wreg_o, stall_cycles);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_wdata;
        logic        exp_wreg;
        int          exp_stall;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [3:0]  rop;
        logic [4:0]  rwd;
        logic        rwreg;
        logic [31:0] rwdata, raddr, rdata, ew;

        vecs[0] = '{"add_pass", MEMOP_NONE, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 32'h1234, 1'b1, 0};
        vecs[1] = '{"sw_100",   MEMOP_SW,   5'd0, 1'b0, 32'h55, 32'h100, 32'hDEADBEEF, 32'h55, 1'b0, 5};
        vecs[2] = '{"lw_100",   MEMOP_LW,   5'd3, 1'b1, 32'h0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 6};
        vecs[3] = '{"lb_103",   MEMOP_LB,   5'd4, 1'b1, 32'h0, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b1, 3};
        vecs[4] = '{"lbu_103",  MEMOP_LBU,  5'd6, 1'b1, 32'h0, 32'h103, 32'h0, 32'h000000DE, 1'b1, 3};
        vecs[5] = '{"lh_101",   MEMOP_LH,   5'd7, 1'b1, 32'h0, 32'h101, 32'h0, 32'hFFFFADBE, 1'b1, 4};
        vecs[6] = '{"lw_x0",    MEMOP_LW,   5'd0, 1'b1, 32'h0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 6};
        vecs[7] = '{"none_x0",  MEMOP_NONE, 5'd0, 1'b1, 32'hABCD, 32'h0, 32'h0, 32'hABCD, 1'b0, 0};
        vecs[8] = '{"sb_104",   MEMOP_SB,   5'd9, 1'b1, 32'h77, 32'h104, 32'h000000A5, 32'h77, 1'b1, 2};
        vecs[9] = '{"lhu_103",  MEMOP_LHU,  5'd8, 1'b1, 32'h0, 32'h103, 32'h0, 32'h0000A5DE, 1'b1, 4};

        // Reset state with live, non-trivial inputs.
        wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234; memop_i = MEMOP_SW;
        mem_addr_i = 32'h100; mem_data_i = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        check("rst stall_req_o", {31'd0, stall_req_o}, 32'd0);
        check("rst ram_wr_o", {31'd0, ram_wr_o}, 32'd0);
        check("rst wdata_o", wdata_o, 32'd0);
        check("rst wd_o", {27'd0, wd_o}, 32'd0);
        check("rst wreg_o", {31'd0, wreg_o}, 32'd0);
        check("rst ram_a_o", 32'(ram_a_o), 32'd0);
        memop_i = MEMOP_NONE;
        rst = 1'b0;

        // Same-cycle passthrough check for the first vector.
        @(posedge clk); #1;
        memop_i = vecs[0].op; wd_i = vecs[0].wd; wreg_i = vecs[0].wreg; wdata_i = vecs[0].wdata;
        #1;
        check("add_pass comb wdata_o", wdata_o, 32'h1234);
        check("add_pass comb stall", {31'd0, stall_req_o}, 32'd0);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].wd, vecs[i].wreg, vecs[i].wdata,
                   vecs[i].addr, vecs[i].data, vecs[i].exp_wdata, vecs[i].exp_wreg,
                   vecs[i].exp_stall);

        // Reset during the second byte of a store aborts it after byte 0.
        run_op("sw_200_clear", MEMOP_SW, 5'd0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h0, 1'b0, 5);
        @(posedge clk); #1;
        memop_i = MEMOP_SW; wd_i = 5'd0; wreg_i = 1'b0; mem_addr_i = 32'h200; mem_data_i = 32'h11223344;
        @(negedge clk);
        check("abort idle ram_wr_o", {31'd0, ram_wr_o}, 32'd0);
        @(negedge clk);
        check("abort byte0 ram_d_o", {24'd0, ram_d_o}, 32'h44);
        @(negedge clk);
        check("abort byte1 ram_wr_o", {31'd0, ram_wr_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort rst ram_wr_o", {31'd0, ram_wr_o}, 32'd0);
        check("abort rst stall", {31'd0, stall_req_o}, 32'd0);
        check("abort rst wdata_o", wdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        memop_i = MEMOP_NONE; wd_i = 5'd2; wreg_i = 1'b1; wdata_i = 32'h99;
        #1;
        check("abort after idle wdata_o", wdata_o, 32'h99);
        check("abort after idle stall", {31'd0, stall_req_o}, 32'd0);
        $display("txn abort_sw_200 rst during byte 1");
        ref_mem[32'h200] = 8'h44;
        run_op("lw_200_after_abort", MEMOP_LW, 5'd1, 1'b1, 32'h0, 32'h200, 32'h0,
               model_load(MEMOP_LW, 32'h200), 1'b1, 6);
        check("abort only byte0 value", model_load(MEMOP_LW, 32'h200), 32'h00000044);

        // Randomized: seed a window with known words, then mixed traffic.
        for (int i = 0; i < 16; i++) begin
            rdata = $urandom;
            run_op("seed_sw", MEMOP_SW, 5'd0, 1'b0, 32'h0, 32'h300 + 32'(4 * i), rdata,
                   32'h0, 1'b0, 5);
        end
        for (int i = 0; i < 60; i++) begin
            rop    = 4'($urandom_range(0, 8));
            rwd    = 5'($urandom_range(0, 31));
            rwreg  = 1'($urandom_range(0, 1));
            rwdata = $urandom;
            raddr  = 32'h300 + 32'($urandom_range(0, 60));
            rdata  = $urandom;
            ew     = (op_bytes(rop) != 0 && !op_is_store(rop)) ? model_load(rop, raddr) : rwdata;
            run_op("rand", rop, rwd, rwreg, rwdata, raddr, rdata, ew,
                   rwreg && (rwd != 5'd0), model_stall(rop));
        end

        @(posedge clk); #1;
        memop_i = MEMOP_NONE;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
